seq_check: RTL and testbench

- Cycle-by-cycle checker for a 4-bit bus against an expected character-string sequence.
- Same character alphabet and character ordering as the stimulus sequence generator.
- A generator and a checker instantiated with the same string pair up directly.
- Used in SVA demos/benches to drive the DUT and confirm its output stream without hand-written compare logic.
- Reports pass/fail, first mismatch position and mismatch count.

---
 rtl/seq_check_pkg.sv | 50 +++++
 rtl/seq_check_if.sv | 23 ++
 rtl/seq_check.sv | 96 +++++++++
 tb/tb_seq_check.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_check_pkg.sv
// Shared character decode, kind/state enums and constants for sequence generator and checker.
// Latency: combinational helpers only.
// Backpressure: none; pure package.
package seq_check_pkg;

  typedef enum logic [1:0] {
    HEX,
    DONTCARE,
    END,
    ILLEGAL
  } kind_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef struct packed {
    kind_e      kind;
    logic [3:0] nib;
  } seq_dec_t;

  localparam logic [7:0] NO_IDX = 8'd255;

  // Map one string byte to its kind and nibble; generator and checker both use this.
  function automatic seq_dec_t seq_char_decode(input logic [7:0] c);
    seq_dec_t d;
    d.kind = ILLEGAL;
    d.nib  = 4'h0;
    if (c >= 8'h30 && c <= 8'h39) begin          // '0'..'9'
      d.kind = HEX;
      d.nib  = c[3:0];
    end else if ((c >= 8'h61 && c <= 8'h66) ||   // 'a'..'f'
                 (c >= 8'h41 && c <= 8'h46)) begin // 'A'..'F'
      d.kind = HEX;
      d.nib  = c[3:0] + 4'd9;
    end else begin
      case (c)
        8'h5F: begin d.kind = HEX; d.nib = 4'h0; end   // '_'
        8'h2D: begin d.kind = HEX; d.nib = 4'hF; end   // '-'
        8'h78, 8'h58, 8'h7A, 8'h5A: d.kind = DONTCARE; // x X z Z
        8'h00: d.kind = END;                            // past end of string
        default: d.kind = ILLEGAL;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/seq_check_if.sv
// Bundle of the checker's run control, observed data and result signals.
// Latency: wires only.
// Backpressure: none; results are level signals held by the checker.
interface seq_check_if;
  logic       start;
  logic [3:0] din;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] mism_cnt;
  logic [7:0] first_idx;
  logic       illegal;

  modport master (
    output start, din,
    input  busy, done, pass, mism_cnt, first_idx, illegal
  );

  modport slave (
    input  start, din,
    output busy, done, pass, mism_cnt, first_idx, illegal
  );
endinterface

// File: rtl/seq_check.sv
// Compares a 4-bit bus against a string-encoded expected sequence, one character per clock.
// Latency: char 0 compared on the start edge; done rises on the edge after the last character.
// Backpressure: none; din is sampled every cycle of a run, start restarts at any time.
module seq_check
  import seq_check_pkg::*;
#(
  parameter int                  MAXLEN = 64,
  // Default is all NUL, i.e. the empty string.
  parameter logic [8*MAXLEN-1:0] SEQ    = '0
) (
  input  logic       clock,
  input  logic       reset,
  seq_check_if.slave bus
);

  localparam int IW = $clog2(MAXLEN + 1);

  state_e        r_state;
  logic [IW-1:0] r_idx;
  logic          r_busy;
  logic          r_done;
  logic [7:0]    r_mism;
  logic [7:0]    r_first;
  logic          r_illegal;

  logic [IW-1:0] w_sel;
  logic [7:0]    w_byte;
  seq_dec_t      w_dec;
  logic          w_mis;

  // Select the character under test; a shift past the packed string yields NUL,
  // so idx == MAXLEN naturally reads as end-of-sequence.
  always_comb begin
    w_sel  = bus.start ? '0 : r_idx;
    w_byte = 8'(SEQ >> {w_sel, 3'b000});
    w_dec  = seq_char_decode(w_byte);
    w_mis  = (w_dec.kind == ILLEGAL) ||
             ((w_dec.kind == HEX) && (bus.din !== w_dec.nib));
  end

  // Run FSM with mismatch counter, first-mismatch index and illegal flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_mism    <= 8'd0;
      r_first   <= NO_IDX;
      r_illegal <= 1'b0;
    end else if (bus.start) begin
      r_idx <= IW'(1);
      if (w_dec.kind == END) begin
        r_state   <= DONE;
        r_busy    <= 1'b0;
        r_done    <= 1'b1;
        r_mism    <= 8'd0;
        r_first   <= NO_IDX;
        r_illegal <= 1'b0;
      end else begin
        r_state   <= RUN;
        r_busy    <= 1'b1;
        r_done    <= 1'b0;
        r_mism    <= {7'd0, w_mis};
        r_first   <= w_mis ? 8'd0 : NO_IDX;
        r_illegal <= (w_dec.kind == ILLEGAL);
      end
    end else begin
      case (r_state)
        RUN: begin
          if (w_dec.kind == END) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
            if (w_mis) begin
              if (r_mism != 8'hFF) r_mism <= r_mism + 8'd1;
              if (r_mism == 8'd0)  r_first <= 8'(r_idx);
            end
            if (w_dec.kind == ILLEGAL) r_illegal <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.mism_cnt  = r_mism;
  assign bus.first_idx = r_first;
  assign bus.illegal   = r_illegal;
  assign bus.pass      = r_done && (r_mism == 8'd0) && !r_illegal;

endmodule

// File: tb/tb_seq_check.sv
// Directed bench for seq_check: several checker instances with different strings.
// Latency: checks done timing relative to the start edge.
// Backpressure: n/a.
module tb_seq_check;
  import seq_check_pkg::*;

  localparam logic [8*64-1:0]  SEQ_A   = 512'("0123");
  localparam logic [8*64-1:0]  SEQ_B   = 512'("x-_5");
  localparam logic [8*64-1:0]  SEQ_C   = 512'("1?2");
  localparam logic [8*64-1:0]  SEQ_D   = 512'("F0A5");
  localparam logic [8*4-1:0]   SEQ_E   = "2345";       // fills MAXLEN=4 exactly, no NUL
  localparam logic [8*8-1:0]   SEQ_F   = 64'd0;        // empty string
  localparam logic [8*300-1:0] SEQ_S   = {300{8'h30}}; // 300 x '0'

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  seq_check_if if_a ();
  seq_check_if if_b ();
  seq_check_if if_c ();
  seq_check_if if_d ();
  seq_check_if if_e ();
  seq_check_if if_f ();
  seq_check_if if_s ();

  seq_check #(.MAXLEN(64),  .SEQ(SEQ_A)) u_a (.clock(clock), .reset(reset), .bus(if_a.slave));
  seq_check #(.MAXLEN(64),  .SEQ(SEQ_B)) u_b (.clock(clock), .reset(reset), .bus(if_b.slave));
  seq_check #(.MAXLEN(64),  .SEQ(SEQ_C)) u_c (.clock(clock), .reset(reset), .bus(if_c.slave));
  seq_check #(.MAXLEN(64),  .SEQ(SEQ_D)) u_d (.clock(clock), .reset(reset), .bus(if_d.slave));
  seq_check #(.MAXLEN(4),   .SEQ(SEQ_E)) u_e (.clock(clock), .reset(reset), .bus(if_e.slave));
  seq_check #(.MAXLEN(8),   .SEQ(SEQ_F)) u_f (.clock(clock), .reset(reset), .bus(if_f.slave));
  seq_check #(.MAXLEN(300), .SEQ(SEQ_S)) u_s (.clock(clock), .reset(reset), .bus(if_s.slave));

  // Bench-side sequence generator for SEQ_D: registered dout, char k out after edge g0+k.
  logic       gen_start   = 1'b0;
  logic [3:0] gen_dout    = 4'h0;
  int         gen_idx     = 64;
  logic       chk_start_q = 1'b0;

  function automatic logic [3:0] gen_nib(input int k);
    seq_dec_t d;
    d = seq_char_decode(SEQ_D[8*k +: 8]);
    return d.nib;
  endfunction

  always @(posedge clock) begin
    chk_start_q <= gen_start;
    if (gen_start) begin
      gen_dout <= gen_nib(0);
      gen_idx  <= 1;
    end else if (gen_idx < 64) begin
      gen_dout <= gen_nib(gen_idx);
      gen_idx  <= gen_idx + 1;
    end
  end

  assign if_d.start = chk_start_q;
  assign if_d.din   = gen_dout;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) tick;
    n_vec++;
    if ({if_a.busy, if_a.done, if_a.pass, if_a.illegal} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags got %b want 0000", {if_a.busy, if_a.done, if_a.pass, if_a.illegal});
    end
    n_vec++;
    if (if_a.mism_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL reset_mism got %0d want 0", if_a.mism_cnt);
    end
    n_vec++;
    if (if_a.first_idx !== 8'd255) begin
      n_err++;
      $display("FAIL reset_first got %0d want 255", if_a.first_idx);
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_basic_pass;
    if_a.start = 1'b1; if_a.din = 4'd3; tick;
    if_a.start = 1'b0; if_a.din = 4'd2; tick;
    if_a.din = 4'd1; tick;
    if_a.din = 4'd0; tick;
    n_vec++;
    if ({if_a.busy, if_a.done} !== 2'b10) begin
      n_err++;
      $display("FAIL basic_latency_t3 got busy/done %b want 10", {if_a.busy, if_a.done});
    end
    if_a.din = 4'hF; tick;
    n_vec++;
    if ({if_a.busy, if_a.done, if_a.pass, if_a.illegal} !== 4'b0110) begin
      n_err++;
      $display("FAIL basic_flags got %b want 0110", {if_a.busy, if_a.done, if_a.pass, if_a.illegal});
    end
    n_vec++;
    if ({if_a.mism_cnt, if_a.first_idx} !== {8'd0, 8'd255}) begin
      n_err++;
      $display("FAIL basic_counts got %0d/%0d want 0/255", if_a.mism_cnt, if_a.first_idx);
    end
    tick;
    n_vec++;
    if (if_a.done !== 1'b1) begin
      n_err++;
      $display("FAIL basic_done_sticky got %b want 1", if_a.done);
    end
  endtask

  task automatic test_mismatch;
    if_a.start = 1'b1; if_a.din = 4'd3; tick;
    n_vec++;
    if ({if_a.done, if_a.busy} !== 2'b01) begin
      n_err++;
      $display("FAIL mism_restart_clears_done got %b want 01", {if_a.done, if_a.busy});
    end
    if_a.start = 1'b0; if_a.din = 4'd2; tick;
    if_a.din = 4'd7; tick;
    if_a.din = 4'd0; tick;
    tick;
    n_vec++;
    if ({if_a.done, if_a.pass, if_a.mism_cnt, if_a.first_idx} !== {1'b1, 1'b0, 8'd1, 8'd2}) begin
      n_err++;
      $display("FAIL mism_result got done=%b pass=%b cnt=%0d first=%0d want 1 0 1 2",
               if_a.done, if_a.pass, if_a.mism_cnt, if_a.first_idx);
    end
  endtask

  task automatic test_dontcare;
    if_b.start = 1'b1; if_b.din = 4'd5; tick;
    if_b.start = 1'b0; if_b.din = 4'd0; tick;
    if_b.din = 4'd15; tick;
    if_b.din = 4'd4; tick;
    tick;
    n_vec++;
    if ({if_b.done, if_b.pass, if_b.mism_cnt} !== {1'b1, 1'b1, 8'd0}) begin
      n_err++;
      $display("FAIL dontcare_pass got done=%b pass=%b cnt=%0d want 1 1 0",
               if_b.done, if_b.pass, if_b.mism_cnt);
    end
    if_b.start = 1'b1; if_b.din = 4'd5; tick;
    if_b.start = 1'b0; if_b.din = 4'd0; tick;
    if_b.din = 4'd14; tick;
    if_b.din = 4'd4; tick;
    tick;
    n_vec++;
    if ({if_b.done, if_b.pass, if_b.mism_cnt, if_b.first_idx} !== {1'b1, 1'b0, 8'd1, 8'd2}) begin
      n_err++;
      $display("FAIL dontcare_dash got done=%b pass=%b cnt=%0d first=%0d want 1 0 1 2",
               if_b.done, if_b.pass, if_b.mism_cnt, if_b.first_idx);
    end
  endtask

  task automatic test_illegal;
    if_c.start = 1'b1; if_c.din = 4'd2; tick;
    if_c.start = 1'b0; if_c.din = 4'd2; tick;
    if_c.din = 4'd1; tick;
    tick;
    n_vec++;
    if ({if_c.done, if_c.illegal, if_c.pass} !== 3'b110) begin
      n_err++;
      $display("FAIL illegal_flags got done/illegal/pass %b want 110", {if_c.done, if_c.illegal, if_c.pass});
    end
    n_vec++;
    if ({if_c.mism_cnt, if_c.first_idx} !== {8'd1, 8'd1}) begin
      n_err++;
      $display("FAIL illegal_counts got %0d/%0d want 1/1", if_c.mism_cnt, if_c.first_idx);
    end
  endtask

  task automatic test_maxlen;
    if_e.start = 1'b1; if_e.din = 4'd5; tick;
    if_e.start = 1'b0; if_e.din = 4'd4; tick;
    if_e.din = 4'd3; tick;
    if_e.din = 4'd2; tick;
    n_vec++;
    if ({if_e.busy, if_e.done} !== 2'b10) begin
      n_err++;
      $display("FAIL maxlen_t3 got busy/done %b want 10", {if_e.busy, if_e.done});
    end
    if_e.din = 4'd9; tick;
    n_vec++;
    if ({if_e.busy, if_e.done, if_e.pass} !== 3'b011) begin
      n_err++;
      $display("FAIL maxlen_end got busy/done/pass %b want 011", {if_e.busy, if_e.done, if_e.pass});
    end
  endtask

  task automatic test_empty;
    if_f.start = 1'b1; if_f.din = 4'd7; tick;
    if_f.start = 1'b0;
    n_vec++;
    if ({if_f.busy, if_f.done, if_f.pass, if_f.mism_cnt} !== {3'b011, 8'd0}) begin
      n_err++;
      $display("FAIL empty_done got busy/done/pass %b cnt=%0d want 011 0",
               {if_f.busy, if_f.done, if_f.pass}, if_f.mism_cnt);
    end
  endtask

  task automatic test_saturate;
    if_s.start = 1'b1; if_s.din = 4'd1; tick;
    if_s.start = 1'b0;
    repeat (299) tick;
    n_vec++;
    if ({if_s.busy, if_s.done, if_s.mism_cnt} !== {2'b10, 8'd255}) begin
      n_err++;
      $display("FAIL sat_run got busy/done %b cnt=%0d want 10 255", {if_s.busy, if_s.done}, if_s.mism_cnt);
    end
    tick;
    n_vec++;
    if ({if_s.done, if_s.pass, if_s.mism_cnt, if_s.first_idx} !== {2'b10, 8'd255, 8'd0}) begin
      n_err++;
      $display("FAIL sat_end got done=%b pass=%b cnt=%0d first=%0d want 1 0 255 0",
               if_s.done, if_s.pass, if_s.mism_cnt, if_s.first_idx);
    end
  endtask

  task automatic test_reset_midrun;
    if_a.start = 1'b1; if_a.din = 4'd9; tick;
    if_a.start = 1'b0; if_a.din = 4'd9; tick;
    n_vec++;
    if ({if_a.busy, if_a.mism_cnt, if_a.first_idx} !== {1'b1, 8'd2, 8'd0}) begin
      n_err++;
      $display("FAIL midrun_pre got busy=%b cnt=%0d first=%0d want 1 2 0",
               if_a.busy, if_a.mism_cnt, if_a.first_idx);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({if_a.busy, if_a.done, if_a.pass, if_a.mism_cnt, if_a.first_idx} !== {3'b000, 8'd0, 8'd255}) begin
      n_err++;
      $display("FAIL midrun_reset got busy/done/pass %b cnt=%0d first=%0d want 000 0 255",
               {if_a.busy, if_a.done, if_a.pass}, if_a.mism_cnt, if_a.first_idx);
    end
    tick;
    reset = 1'b0;
    tick;
    if_a.start = 1'b1; if_a.din = 4'd3; tick;
    if_a.start = 1'b0; if_a.din = 4'd2; tick;
    if_a.din = 4'd1; tick;
    if_a.din = 4'd0; tick;
    tick;
    n_vec++;
    if ({if_a.done, if_a.pass} !== 2'b11) begin
      n_err++;
      $display("FAIL midrun_fresh got done/pass %b want 11", {if_a.done, if_a.pass});
    end
  endtask

  task automatic test_paired;
    gen_start = 1'b1; tick;   // edge g0
    gen_start = 1'b0;
    repeat (5) tick;          // checker started at g0+1, done after g0+5
    n_vec++;
    if ({if_d.done, if_d.pass, if_d.mism_cnt} !== {2'b11, 8'd0}) begin
      n_err++;
      $display("FAIL paired_pass got done/pass %b cnt=%0d want 11 0", {if_d.done, if_d.pass}, if_d.mism_cnt);
    end
  endtask

  task automatic test_back_to_back;
    gen_start = 1'b1; tick;   // g0
    gen_start = 1'b0; tick;   // g0+1: checker run 1 starts
    gen_start = 1'b1; tick;   // g1 = g0+2
    gen_start = 1'b0; tick;   // g1+1: checker restarts
    tick; tick;               // g1+3: old run would have finished here
    n_vec++;
    if ({if_d.busy, if_d.done} !== 2'b10) begin
      n_err++;
      $display("FAIL b2b_no_early_done got busy/done %b want 10", {if_d.busy, if_d.done});
    end
    tick;                     // g1+4
    n_vec++;
    if ({if_d.busy, if_d.done} !== 2'b10) begin
      n_err++;
      $display("FAIL b2b_t4 got busy/done %b want 10", {if_d.busy, if_d.done});
    end
    tick;                     // g1+5
    n_vec++;
    if ({if_d.done, if_d.pass, if_d.mism_cnt} !== {2'b11, 8'd0}) begin
      n_err++;
      $display("FAIL b2b_pass got done/pass %b cnt=%0d want 11 0", {if_d.done, if_d.pass}, if_d.mism_cnt);
    end
  endtask

  initial begin
    if_a.start = 1'b0; if_a.din = 4'd0;
    if_b.start = 1'b0; if_b.din = 4'd0;
    if_c.start = 1'b0; if_c.din = 4'd0;
    if_e.start = 1'b0; if_e.din = 4'd0;
    if_f.start = 1'b0; if_f.din = 4'd0;
    if_s.start = 1'b0; if_s.din = 4'd0;
    test_reset;
    test_basic_pass;
    test_mismatch;
    test_dontcare;
    test_illegal;
    test_maxlen;
    test_empty;
    test_saturate;
    test_reset_midrun;
    test_paired;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
